rmw_sched: RTL

RMW_SCHED -- requirements
Module: rmw_sched

---
 rtl/rmw_sched_pkg.sv | 27 ++
 rtl/rmw_sched_if.sv | 31 +++
 rtl/rmw_fifo.sv | 71 +++++++
 rtl/rmw_sched.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rmw_sched_pkg.sv
// Shared encodings for the read-modify-write scheduler.
// Holds the RMW function codes, the scheduler FSM states and the queue entry.
package rmw_sched_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        FN_INC = 2'b00,
        FN_DEP = 2'b01,
        FN_LSR = 2'b10,
        FN_ASL = 2'b11
    } rmw_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        rmw_fn_e           fn;
        logic              wr_flags;
        logic              carry_mask;
    } rmw_req_t;

endpackage

// File: rtl/rmw_sched_if.sv
// Decoder-to-scheduler request channel (valid/ready).
// The decoder drives the master side, the scheduler sits on the slave side.
interface rmw_sched_if;
    import rmw_sched_pkg::*;

    logic              dec_valid;
    logic [ADDR_W-1:0] dec_addr;
    logic [1:0]        dec_fn;
    logic              dec_wr_flags;
    logic              dec_carry_mask;
    logic              dec_ready;

    modport master (
        output dec_valid,
        output dec_addr,
        output dec_fn,
        output dec_wr_flags,
        output dec_carry_mask,
        input  dec_ready
    );

    modport slave (
        input  dec_valid,
        input  dec_addr,
        input  dec_fn,
        input  dec_wr_flags,
        input  dec_carry_mask,
        output dec_ready
    );

endinterface

// File: rtl/rmw_fifo.sv
// Circular request queue for the RMW scheduler.
// Exposes per-entry address/valid so the owner can snoop every queued slot.
module rmw_fifo
    import rmw_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          a_rst,
    input  logic                          push,
    input  rmw_req_t                      push_data,
    input  logic                          pop,
    output rmw_req_t                      head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
    output logic [DEPTH-1:0]              entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rmw_req_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] off;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Payload is qualified by the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_comb begin
        off         = '0;
        entry_addr  = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, off} < count);
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/rmw_sched.sv
// Read-modify-write scheduler: queues decoded RMW ops, issues the load,
// strobes the RMW ALU and stalls conflicting snooped accesses.
module rmw_sched
    import rmw_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              a_rst,
    rmw_sched_if.slave        dec,
    output logic              lsu_ld_req,
    output logic [ADDR_W-1:0] lsu_ld_addr,
    input  logic              lsu_ld_ack,
    output logic              sched_rmw,
    output logic [ADDR_W-1:0] sched_addr,
    output logic [1:0]        sched_rmw_fn,
    output logic              sched_wr_flags,
    output logic              sched_carry_mask,
    input  logic              rmw_wr_done,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_stall,
    output logic              busy
);

    sched_state_e             state;
    sched_state_e             state_nxt;
    logic [ADDR_W-1:0]        inflight_addr;
    rmw_req_t                 push_data;
    rmw_req_t                 head;
    logic                     push;
    logic                     ld_fire;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic [DEPTH-1:0]         entry_valid;
    logic                     q_hit;
    logic                     exec_hit;

    assign dec.dec_ready = ~full;
    assign push          = dec.dec_valid & ~full;

    always_comb begin
        push_data            = '0;
        push_data.addr       = dec.dec_addr;
        push_data.fn         = rmw_fn_e'(dec.dec_fn);
        push_data.wr_flags   = dec.dec_wr_flags;
        push_data.carry_mask = dec.dec_carry_mask;
    end

    rmw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .a_rst       (a_rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (ld_fire),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst)
            inflight_addr <= '0;
        else if (ld_fire)
            inflight_addr <= head.addr;
    end

    // The pop happens on the load ack, so count in EXEC is already post-pop.
    always_comb begin
        state_nxt  = state;
        lsu_ld_req = 1'b0;
        ld_fire    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (count != '0)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                lsu_ld_req = 1'b1;
                if (lsu_ld_ack) begin
                    ld_fire   = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (rmw_wr_done)
                    state_nxt = (count != '0) ? ST_LOAD : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sched_rmw        = ld_fire;
        sched_addr       = '0;
        sched_rmw_fn     = FN_INC;
        sched_wr_flags   = 1'b0;
        sched_carry_mask = 1'b0;
        lsu_ld_addr      = '0;
        if (lsu_ld_req)
            lsu_ld_addr = head.addr;
        if (ld_fire) begin
            sched_addr       = head.addr;
            sched_rmw_fn     = head.fn;
            sched_wr_flags   = head.wr_flags;
            sched_carry_mask = head.carry_mask;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == snoop_addr))
                q_hit = 1'b1;
        end
    end

    assign exec_hit    = (state == ST_EXEC) && (inflight_addr == snoop_addr);
    assign snoop_stall = snoop_valid & (q_hit | exec_hit);
    assign busy        = ~empty | (state != ST_IDLE);

endmodule
